booth_pp_stage: RTL and testbench

//  Upstream feeder of the 4-row Wallace tree. Accepts an unsigned multiplicand/multiplier pair

---
 rtl/mult_pkg.sv | 22 ++
 rtl/booth_pp_stage_if.sv | 29 ++
 rtl/booth_pp_stage_pp_digit_mux.sv | 20 ++
 rtl/booth_pp_stage.sv | 86 ++++++++
 tb/tb_booth_pp_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared widths, partial-product type and radix-4 digit encodings for the
// Booth partial-product stage.
package mult_pkg;
    localparam int MBITS = 12;
    localparam int NBITS = 8;
    localparam int NPP   = NBITS / 2;
    localparam int PPW   = MBITS + 1;
    localparam int AW    = MBITS - 1;
    localparam int TAG_W = 4;

    typedef logic [PPW-1:0] pp_t;

    localparam logic [1:0] DIG_ZERO  = 2'd0;
    localparam logic [1:0] DIG_ONE   = 2'd1;
    localparam logic [1:0] DIG_TWO   = 2'd2;
    localparam logic [1:0] DIG_THREE = 2'd3;

    // 3A as a zero-extended lane-width add; AW is two bits short of PPW so it cannot wrap.
    function automatic pp_t triple(input logic [AW-1:0] a);
        return {2'b00, a} + {1'b0, a, 1'b0};
    endfunction
endpackage

// File: rtl/booth_pp_stage_if.sv
// Operand/partial-product handshake bundle; tag lines exist only with BOOTH_PP_TAG_EN.
interface booth_pp_stage_if;
    import mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     a;
    logic [NBITS-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    pp_t               pp0;
    pp_t               pp1;
    pp_t               pp2;
    pp_t               pp3;
`ifdef BOOTH_PP_TAG_EN
    logic [TAG_W-1:0]  in_tag;
    logic [TAG_W-1:0]  out_tag;

    modport master (output in_valid, a, b, in_tag, out_ready,
                    input  in_ready, out_valid, pp0, pp1, pp2, pp3, out_tag);
    modport slave  (input  in_valid, a, b, in_tag, out_ready,
                    output in_ready, out_valid, pp0, pp1, pp2, pp3, out_tag);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, pp0, pp1, pp2, pp3);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, pp0, pp1, pp2, pp3);
`endif
endinterface

// File: rtl/booth_pp_stage_pp_digit_mux.sv
// One radix-4 lane: selects 0, A, 2A or the precomputed 3A from a 2-bit digit.
module pp_digit_mux
    import mult_pkg::*;
(
    input  logic [1:0]    digit,
    input  logic [AW-1:0] a,
    input  pp_t           a3,
    output pp_t           pp
);
    always_comb begin
        pp = '0;
        case (digit)
            DIG_ZERO:  pp = '0;
            DIG_ONE:   pp = {2'b00, a};
            DIG_TWO:   pp = {1'b0, a, 1'b0};
            DIG_THREE: pp = a3;
            default:   pp = '0;
        endcase
    end
endmodule

// File: rtl/booth_pp_stage.sv
// Two-stage elastic radix-4 partial-product generator feeding the Wallace tree.
// Optional sideband tag enabled by defining BOOTH_PP_TAG_EN.
module booth_pp_stage
    import mult_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    booth_pp_stage_if.slave bus
);
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s1_load;
    logic                     s2_adv;
    logic [AW-1:0]            s1_a;
    logic [NBITS-1:0]         s1_b;
    pp_t                      s1_a3;
    logic [NPP-1:0][PPW-1:0]  pp_nxt;
    logic [NPP-1:0][PPW-1:0]  pp_q;

    // Stage 2 drains or refills in the same cycle, so stage 1 never stalls a
    // moving pipe.
    assign s2_adv       = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s2_adv;
    assign s1_load      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_a3    <= '0;
            pp_q     <= '0;
        end else begin
            if (s1_load) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_a3 <= triple(bus.a);
            end
            if (s1_load)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;
            if (s2_adv) begin
                s2_valid <= 1'b1;
                pp_q     <= pp_nxt;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < NPP; i++) begin : g_lane
            pp_digit_mux u_mux (
                .digit (s1_b[2*i +: 2]),
                .a     (s1_a),
                .a3    (s1_a3),
                .pp    (pp_nxt[i])
            );
        end
    endgenerate

`ifdef BOOTH_PP_TAG_EN
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag <= '0;
            s2_tag <= '0;
        end else begin
            if (s1_load) s1_tag <= bus.in_tag;
            if (s2_adv)  s2_tag <= s1_tag;
        end
    end

    assign bus.out_tag = s2_tag;
`endif

    assign bus.out_valid = s2_valid;
    assign bus.pp0       = pp_q[0];
    assign bus.pp1       = pp_q[1];
    assign bus.pp2       = pp_q[2];
    assign bus.pp3       = pp_q[3];
endmodule

// File: tb/tb_booth_pp_stage.sv
// Self-checking bench for booth_pp_stage: directed corners plus random traffic
// against an arithmetic reference (pp_i = A * digit_i, sum = A*B).
module tb_booth_pp_stage;
    import mult_pkg::*;

    typedef struct packed {
        logic [3:0]        tag;
        logic [31:0]       prod;
        logic [3:0][12:0]  pp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    booth_pp_stage_if bus();

    booth_pp_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          fires  = 0;
    exp_t        exp_q[$];
    bit          hold_chk = 0;
    logic [51:0] held;
    logic [3:0]  held_tag;
    logic [3:0]  tg;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    function automatic logic [51:0] pp_cat();
        return {bus.pp3, bus.pp2, bus.pp1, bus.pp0};
    endfunction

    function automatic logic [31:0] pp_sum();
        return 32'(bus.pp0) + (32'(bus.pp1) << 2) + (32'(bus.pp2) << 4) + (32'(bus.pp3) << 6);
    endfunction

    function automatic logic [3:0] cur_tag();
`ifdef BOOTH_PP_TAG_EN
        return bus.out_tag;
`else
        return 4'd0;
`endif
    endfunction

    function automatic exp_t model(input int unsigned av, input int unsigned bv, input logic [3:0] t);
        exp_t e;
        for (int i = 0; i < 4; i++)
            e.pp[i] = 13'(av * ((bv >> (2 * i)) % 4));
        e.prod = 32'(av * bv);
        e.tag  = t;
        return e;
    endfunction

    task automatic set_in(input int unsigned av, input int unsigned bv);
        bus.a = AW'(av);
        bus.b = NBITS'(bv);
        tg    = 4'($urandom);
`ifdef BOOTH_PP_TAG_EN
        bus.in_tag = tg;
`endif
    endtask

    task automatic rand_in();
        set_in($urandom_range(0, 2047), $urandom_range(0, 255));
    endtask

    // One clock: sample at negedge, score outputs, record accepts, then step.
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (hold_chk) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_pp", 64'(pp_cat()), 64'(held));
`ifdef BOOTH_PP_TAG_EN
            chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
            fires++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pp", 64'(pp_cat()), 64'(e.pp));
                chk("product", 64'(pp_sum()), 64'(e.prod));
`ifdef BOOTH_PP_TAG_EN
                chk("tag", 64'(bus.out_tag), 64'(e.tag));
`endif
            end
        end
        if (acc) exp_q.push_back(model(bus.a, bus.b, tg));
        hold_chk = bus.out_valid && !bus.out_ready;
        held     = pp_cat();
        held_tag = cur_tag();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int base;
        int budget;

        // Reset held with in_valid asserted
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_in(5, 8'h9C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_pp", 64'(pp_cat()), 64'd0);
        chk("rst_tag", 64'(cur_tag()), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rdy_after_rst", 64'(bus.in_ready), 64'd1);

        // a=5, b=9C: out_valid two cycles after the accept cycle
        tick(acc);
        chk("accept_5", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        tick(acc);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_pp", 64'(pp_cat()), 64'({13'd10, 13'd5, 13'd15, 13'd0}));
        chk("lat_sum", 64'(pp_sum()), 64'd780);
        tick(acc);

        // A3 corner
        bus.in_valid = 1'b1;
        set_in(2047, 8'hFF);
        tick(acc);
        bus.in_valid = 1'b0;
        tick(acc);
        chk("max_valid", 64'(bus.out_valid), 64'd1);
        chk("max_pp", 64'(pp_cat()), 64'({4{13'h17FD}}));
        chk("max_sum", 64'(pp_sum()), 64'd521985);
        tick(acc);

        // 8 back-to-back pairs, no bubbles
        base = fires;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_in();
            tick(acc);
            chk("stream_ready", 64'(acc), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick(acc);
        tick(acc);
        chk("stream_fires", 64'(fires - base), 64'd8);
        chk("stream_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure for 5 cycles while streaming
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_in();
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            if (acc) rand_in();
        end
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        budget = 30;
        while ((exp_q.size() > 0 || bus.in_valid) && budget > 0) begin
            tick(acc);
            if (acc) bus.in_valid = 1'b0;
            budget--;
        end
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_in_idle", 64'(bus.in_valid), 64'd0);

        // Reset with two pairs in flight
        bus.in_valid = 1'b1;
        rand_in();
        tick(acc);
        rand_in();
        tick(acc);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_pp", 64'(pp_cat()), 64'd0);
        exp_q.delete();
        hold_chk = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = fires;
        repeat (4) tick(acc);
        chk("midrst_no_emit", 64'(fires - base), 64'd0);

        // Random valid/ready traffic
        for (int i = 0; i < 120; i++) begin
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                rand_in();
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            tick(acc);
            budget--;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
